// File: rtl/pad_serdes.sv
// pad_serdes -- bit-serial pad framing engine between the pad ring and the core.
//
// Input side: LANES bit-serial lanes (MSB first) are collected into parallel
// words of DATA_W bits per lane. A frame that drops s_valid part-way through a
// word discards the partial bits and raises err_frag for one cycle.
// Output side: parallel results are queued in a FIFO_DEPTH-entry FIFO and sent
// MSB first on o_valid/o_bit. Consecutive queued words go out back to back.
//
// Optional feature (macro PAD_SERDES_PARITY_EN): each output word is followed
// by one even-parity bit (XOR of its OUT_W data bits).
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   s_valid, s_data     serial input frame valid / one bit per lane
//   w_valid, w_data     one-cycle strobe / assembled word (lane i at [i*DATA_W +: DATA_W])
//   err_frag            one-cycle pulse: frame ended mid-word
//   r_valid, r_data     parallel result offered to the queue
//   r_ready             queue can accept (not full)
//   o_valid, o_bit      serial output bit valid / serial output bit
module pad_serdes #(
  parameter int DATA_W     = 8,
  parameter int LANES      = 1,
  parameter int OUT_W      = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  input  logic [LANES-1:0]          s_data,
  output logic                      w_valid,
  output logic [DATA_W*LANES-1:0]   w_data,
  output logic                      err_frag,
  input  logic                      r_valid,
  input  logic [OUT_W-1:0]          r_data,
  output logic                      r_ready,
  output logic                      o_valid,
  output logic                      o_bit
);

  // ---------------------------------------------------------------------------
  // Deserializer
  // ---------------------------------------------------------------------------
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [BW-1:0]                  bcnt_q;
  logic [LANES-1:0][DATA_W-1:0]   sr_q;
  logic [LANES-1:0][DATA_W-1:0]   word_d;
  logic                           w_valid_q;
  logic [LANES-1:0][DATA_W-1:0]   w_data_q;
  logic                           err_frag_q;
  logic                           bit_last;

  // Shift registers with the current cycle's bits already appended, so the
  // final bit of a word lands in w_data on the same edge it is sampled.
  always_comb begin
    word_d = '0;
    for (int i = 0; i < LANES; i++) begin
      word_d[i] = {sr_q[i][DATA_W-2:0], s_data[i]};
    end
  end

  assign bit_last = (bcnt_q == BW'(DATA_W - 1));

  // Partial-word contents need no clearing: a completed word always overwrites
  // every bit of the shift register before it is used.
  always_ff @(posedge clk) begin
    if (s_valid) begin
      sr_q <= word_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q     <= '0;
      w_valid_q  <= 1'b0;
      w_data_q   <= '0;
      err_frag_q <= 1'b0;
    end else begin
      w_valid_q  <= 1'b0;
      err_frag_q <= 1'b0;
      if (s_valid) begin
        if (bit_last) begin
          bcnt_q    <= '0;
          w_valid_q <= 1'b1;
          w_data_q  <= word_d;
        end else begin
          bcnt_q <= bcnt_q + BW'(1);
        end
      end else if (bcnt_q != '0) begin
        // Frame dropped mid-word: discard partial bits and flag it.
        bcnt_q     <= '0;
        err_frag_q <= 1'b1;
      end
    end
  end

  assign w_valid  = w_valid_q;
  assign w_data   = w_data_q;
  assign err_frag = err_frag_q;

  // ---------------------------------------------------------------------------
  // Output queue
  // ---------------------------------------------------------------------------
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;
  logic             rdy_q;
  logic             push;
  logic             pop;
  logic [OUT_W-1:0] head;

  // rdy_q mirrors !full of the count register; being a flop it also reads 0
  // while reset is held. A pop in a full cycle cannot make room for a push.
  assign push  = r_valid & rdy_q;
  assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  assign head  = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= r_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != (AW+1)'(FIFO_DEPTH));
    end
  end

  assign r_ready = rdy_q;

  // ---------------------------------------------------------------------------
  // Serializer
  // ---------------------------------------------------------------------------
`ifdef PAD_SERDES_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Index of the final bit slot of a word (data LSB, or the parity bit).
  localparam int LAST = OUT_W - 1 + PAR_BITS;
  localparam int SW   = $clog2(LAST + 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e           state_q;
  logic [SW-1:0]    scnt_q;
  logic [OUT_W-1:0] sh_q;
  logic             o_valid_q;
  logic             slot_last;

  assign slot_last = (scnt_q == SW'(LAST));
  // Pop when idle, or on the final slot of a word so the next word follows
  // with no gap.
  assign pop = (cnt_q != '0) && ((state_q == S_IDLE) || slot_last);

`ifdef PAD_SERDES_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (pop) begin
      par_q <= ^head;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      scnt_q    <= '0;
      sh_q      <= '0;
      o_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            sh_q      <= head;
            scnt_q    <= '0;
            o_valid_q <= 1'b1;
            state_q   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (slot_last) begin
            if (pop) begin
              sh_q   <= head;
              scnt_q <= '0;
            end else begin
              sh_q      <= '0;
              o_valid_q <= 1'b0;
              state_q   <= S_IDLE;
            end
`ifdef PAD_SERDES_PARITY_EN
          end else if (scnt_q == SW'(OUT_W - 1)) begin
            // Data LSB is on the pin now; the parity bit goes out next.
            sh_q   <= {par_q, {(OUT_W-1){1'b0}}};
            scnt_q <= scnt_q + SW'(1);
`endif
          end else begin
            sh_q   <= sh_q << 1;
            scnt_q <= scnt_q + SW'(1);
          end
        end
        default: begin
          state_q   <= S_IDLE;
          o_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid = o_valid_q;
  assign o_bit   = sh_q[OUT_W-1];

endmodule

// File: tb/tb_pad_serdes.sv
module tb_pad_serdes;
  localparam int DATA_W     = 8;
  localparam int LANES      = 2;
  localparam int OUT_W      = 20;
  localparam int FIFO_DEPTH = 4;
`ifdef PAD_SERDES_PARITY_EN
  localparam int NB = OUT_W + 1;
`else
  localparam int NB = OUT_W;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    s_valid;
  logic [LANES-1:0]        s_data;
  logic                    w_valid;
  logic [DATA_W*LANES-1:0] w_data;
  logic                    err_frag;
  logic                    r_valid;
  logic [OUT_W-1:0]        r_data;
  logic                    r_ready;
  logic                    o_valid;
  logic                    o_bit;

  pad_serdes #(
    .DATA_W(DATA_W), .LANES(LANES), .OUT_W(OUT_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data),
    .w_valid(w_valid), .w_data(w_data), .err_frag(err_frag),
    .r_valid(r_valid), .r_data(r_data), .r_ready(r_ready),
    .o_valid(o_valid), .o_bit(o_bit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected serial image of one result word, MSB first, parity appended.
  function automatic logic [31:0] exp_stream(input logic [OUT_W-1:0] d);
`ifdef PAD_SERDES_PARITY_EN
    return {11'd0, d, ^d};
`else
    return {12'd0, d};
`endif
  endfunction

  // Drive n bits of a two-lane word MSB first; count strobes seen before the last bit.
  task automatic send_word(input logic [7:0] l0, input logic [7:0] l1, input int n, output int early);
    early = 0;
    for (int j = 0; j < n; j++) begin
      s_valid = 1'b1;
      s_data  = {l1[7-j], l0[7-j]};
      tick();
      if (j < n - 1 && w_valid) early++;
    end
  endtask

  // Serial output monitor, sampled mid-cycle.
  logic mon_q[$];
  bit   mon_en = 1'b0;
  int   run = 0;
  int   max_run = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_valid) begin
        mon_q.push_back(o_bit);
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
  end

  logic [OUT_W-1:0] words [5] = '{20'h12345, 20'hFEDCB, 20'h00F0F, 20'h80001, 20'h5A5A5};

  initial begin
    int early;
    int cnt;
    int w;
    logic [31:0] bits;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; r_valid = 1'b0; r_data = '0;
    tick(); tick();
    check_eq("rst w_valid", w_valid, 0);
    check_eq("rst w_data", w_data, 0);
    check_eq("rst err_frag", err_frag, 0);
    check_eq("rst o_valid", o_valid, 0);
    check_eq("rst o_bit", o_bit, 0);
    check_eq("rst r_ready", r_ready, 0);
    rst = 1'b0;
    tick();
    check_eq("post-rst r_ready", r_ready, 1);

    // Single word: lane0 A5, lane1 F0.
    send_word(8'hA5, 8'hF0, 8, early);
    check_eq("A early strobe", early, 0);
    check_eq("A w_valid", w_valid, 1);
    check_eq("A w_data", w_data, 16'hF0A5);
    s_valid = 1'b0;
    tick();
    check_eq("A strobe width", w_valid, 0);
    check_eq("A w_data hold", w_data, 16'hF0A5);
    check_eq("A no err", err_frag, 0);

    // Two words back to back with no gap.
    send_word(8'h3C, 8'h81, 8, early);
    check_eq("B1 w_data", {w_valid, w_data}, {1'b1, 16'h813C});
    send_word(8'h5A, 8'h0F, 8, early);
    check_eq("B2 early strobe", early, 0);
    check_eq("B2 w_data", {w_valid, w_data}, {1'b1, 16'h0F5A});
    s_valid = 1'b0;
    tick();
    check_eq("B no err", err_frag, 0);

    // Fragment: five bits then s_valid low.
    send_word(8'hFF, 8'hFF, 5, early);
    check_eq("C frag early", early, 0);
    check_eq("C frag w_valid", w_valid, 0);
    s_valid = 1'b0;
    tick();
    check_eq("C err_frag", err_frag, 1);
    check_eq("C no strobe", w_valid, 0);
    tick();
    check_eq("C err pulse", err_frag, 0);
    send_word(8'hC3, 8'h7E, 8, early);
    check_eq("C recover", {w_valid, w_data}, {1'b1, 16'h7EC3});
    s_valid = 1'b0;
    tick();

    // Single result 20'hABCDE into idle serializer.
    r_valid = 1'b1; r_data = 20'hABCDE;
    tick();
    r_valid = 1'b0;
    check_eq("D t+1 o_valid", o_valid, 0);
    tick();
    bits = '0; cnt = 0;
    for (int k = 0; k < NB; k++) begin
      cnt += int'(o_valid);
      bits = {bits[30:0], o_bit};
      tick();
    end
    check_eq("D valid cycles", cnt, NB);
    check_eq("D bits", bits, exp_stream(20'hABCDE));
    check_eq("D end o_valid", o_valid, 0);

    // LSB-only word: final data bit (and parity bit) is 1.
    r_valid = 1'b1; r_data = 20'h00001;
    tick();
    r_valid = 1'b0;
    tick();
    bits = '0; cnt = 0;
    for (int k = 0; k < NB; k++) begin
      cnt += int'(o_valid);
      bits = {bits[30:0], o_bit};
      tick();
    end
    check_eq("P valid cycles", cnt, NB);
    check_eq("P bits", bits, exp_stream(20'h00001));
    check_eq("P end o_valid", o_valid, 0);

    // Five results with r_valid held: fill, back-pressure, contiguous output.
    mon_q.delete(); run = 0; max_run = 0; mon_en = 1'b1;
    r_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      r_data = words[i];
      w = 0;
      while (!r_ready && w < 50) begin
        tick();
        w++;
      end
      check_eq($sformatf("E push wait %0d", i), w, 0);
      tick();
    end
    r_valid = 1'b0;
    check_eq("E full r_ready", r_ready, 0);
    w = 0;
    while (!r_ready && w < 100) begin
      tick();
      w++;
    end
    check_eq("E ready return", w, NB - 3);
    w = 0;
    while ((mon_q.size() < 5 * NB || o_valid) && w < 400) begin
      tick();
      w++;
    end
    tick();
    mon_en = 1'b0;
    check_eq("E bit count", mon_q.size(), 5 * NB);
    check_eq("E contiguous run", max_run, 5 * NB);
    if (mon_q.size() == 5 * NB) begin
      for (int i = 0; i < 5; i++) begin
        bits = '0;
        for (int k = 0; k < NB; k++) bits = {bits[30:0], mon_q[i * NB + k]};
        check_eq($sformatf("E word %0d", i), bits, exp_stream(words[i]));
      end
    end

    // Reset mid-shift with queued data and mid-word on the input.
    r_valid = 1'b1; r_data = 20'hFFFFF; s_valid = 1'b1; s_data = 2'b11;
    tick();
    tick();
    r_valid = 1'b0;
    tick();
    check_eq("F shifting", o_valid, 1);
    rst = 1'b1; s_valid = 1'b0;
    tick();
    check_eq("F rst w_valid", w_valid, 0);
    check_eq("F rst w_data", w_data, 0);
    check_eq("F rst err_frag", err_frag, 0);
    check_eq("F rst o_valid", o_valid, 0);
    check_eq("F rst o_bit", o_bit, 0);
    check_eq("F rst r_ready", r_ready, 0);
    tick();
    check_eq("F rst hold err", err_frag, 0);
    rst = 1'b0;
    tick();
    check_eq("F release r_ready", r_ready, 1);
    check_eq("F release err", err_frag, 0);
    cnt = 0; early = 0;
    for (int k = 0; k < 30; k++) begin
      cnt += int'(o_valid);
      early += int'(err_frag);
      tick();
    end
    check_eq("F fifo flushed", cnt, 0);
    check_eq("F no err after rst", early, 0);
    send_word(8'h96, 8'h69, 8, early);
    check_eq("F decode after rst", {w_valid, w_data}, {1'b1, 16'h6996});
    s_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pad_serdes.md
# pad_serdes

Bit-serial pad-side framing engine between the chip's I/O pad ring and the compute core. On the input side it collects multi-lane bit-serial words into parallel words. On the output side it queues parallel results and emits them bit-serially on a valid/bit pin pair. It generalises the single-bit serial pins of the current chip top to parametrised word width, lane count and output queue depth, and adds fragment detection and back-pressure, which the current top does not have.

## Interface
Parameters:
- DATA_W, 8, bits per input word per lane (≥2)
- LANES, 1, number of parallel serial input lanes (1..8)
- OUT_W, 20, bits per output result word (≥2)
- FIFO_DEPTH, 4, output result queue depth (power of two, ≥2)

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  serial input frame valid
- s_data  in  LANES  serial input bits, one per lane, MSB first
- w_valid  out  1  one-cycle strobe, assembled word on w_data
- w_data  out  DATA_W*LANES  lane i at [i*DATA_W +: DATA_W]
- err_frag  out  1  one-cycle pulse: frame ended mid-word
- r_valid  in  1  parallel result offered
- r_data  in  OUT_W  parallel result
- r_ready  out  1  queue can accept (high = not full)
- o_valid  out  1  serial output bit valid
- o_bit  out  1  serial output bit, MSB first

## Operation
- Deserializer: bit counter bcnt 0..DATA_W-1. Each cycle with s_valid=1, every lane shifts s_data[i] into its shift register LSB and bcnt increments.
- When bcnt==DATA_W-1 and s_valid=1, the completed word is registered to w_data, w_valid=1 next cycle, and bcnt wraps to 0. Consecutive words need no gap.
- s_valid falling with bcnt≠0: partial bits are discarded, bcnt←0, and err_frag=1 for one cycle. No w_valid is produced. s_valid low with bcnt==0 has no effect.
- w_data holds its last value between strobes.
- Serializer queue: FIFO of FIFO_DEPTH×OUT_W. A push happens on r_valid&r_ready. r_ready = !full, computed from the registered count only. When full, a same-cycle pop does not allow a push.
- Serializer FSM, two states:
  - IDLE: o_valid=0. If the FIFO is non-empty, pop into the shifter, set scnt←0, go to SHIFT.
  - SHIFT: o_valid=1, o_bit=shifter MSB, shift left each cycle. At scnt==OUT_W-1: if the FIFO is non-empty, pop and reload in the same cycle (stay in SHIFT, no gap); otherwise go to IDLE.
- Deserializer and serializer are independent. Simultaneous activity on both sides is legal.
- Reset (any time, including mid-word or mid-shift): bcnt←0, shifter and FIFO flushed, FSM←IDLE. No err_frag is generated for a reset-aborted frame.

## Timing
- Reset values: w_valid=0, w_data=0, err_frag=0, o_valid=0, o_bit=0, r_ready=0 while rst=1. r_ready=1 in the first cycle after rst deasserts.
- Input latency: for a word whose MSB is sampled in cycle k, w_valid=1 in cycle k+DATA_W.
- err_frag: 1 in the cycle after the first cycle with s_valid=0 following a partial word.
- Output latency: a result accepted in cycle t into an empty FIFO with FSM IDLE has its MSB on o_bit with o_valid=1 in cycle t+2. o_valid stays high for exactly OUT_W cycles per word.
- Back-to-back: if the LSB of word n is in cycle c and word n+1 is queued by cycle c-1, the MSB of word n+1 is in cycle c+1.
- All outputs are registered. No combinational path from inputs to outputs except r_ready, which is derived from the count register only.

## Configuration
- PAD_SERDES_PARITY_EN defined:
  - Each output word is followed by one even-parity bit (XOR of the OUT_W data bits), so o_valid is high for OUT_W+1 cycles per word.
  - The back-to-back reload happens after the parity bit.
- Undefined: no parity bit; behaviour exactly as above.

## Test plan
- LANES=2, DATA_W=8: lane0 bits 1,0,1,0,0,1,0,1 and lane1 bits 1,1,1,1,0,0,0,0 on 8 consecutive s_valid cycles -> single w_valid pulse in cycle 8 with w_data=16'hF0A5.
- s_valid high for 5 cycles, then low -> err_frag=1 one cycle later, no w_valid. A following full 8-bit frame decodes correctly.
- OUT_W=20: push 20'hABCDE into an idle block in cycle t -> o_valid=1 in cycles t+2..t+21, bits 1010_1011_1100_1101_1110.
- Push 5 words with FIFO_DEPTH=4 while r_valid is held -> r_ready drops after the buffer fills. All words are emitted contiguously in order, o_valid high for 100 consecutive cycles.
- Assert rst mid-shift and mid-word -> all outputs 0 next cycle, FIFO empty, no err_frag, r_ready=1 the cycle after release.
- With PAD_SERDES_PARITY_EN, push 20'h00001 -> 21 valid bits, the last bit =1.
